// File: rtl/spi_slave_tx_feeder.sv
// Feeds 32-bit TX FIFO words plus the bit-count reload into the SPI slave shifter.
// Reloads gaplessly on the shifter's done pulse and substitutes zero words on underrun.
module spi_slave_tx_feeder #(
   parameter int LEN_W = 16
) (
   input  logic             sclk,
   input  logic             sys_rstn,
   input  logic             start,
   input  logic [LEN_W-1:0] len_words,
   input  logic             en_quad,
   input  logic             abort,
   input  logic [31:0]      fifo_data,
   input  logic             fifo_valid,
   output logic             fifo_ready,
   output logic [31:0]      tx_data,
   output logic             tx_data_valid,
   output logic [7:0]       tx_counter,
   output logic             tx_counter_upd,
   output logic             tx_en_quad,
   input  logic             tx_done,
   output logic             busy,
   output logic             xfer_done,
   output logic             underrun,
   output logic [LEN_W-1:0] words_sent
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] remaining_q, remaining_d;
   logic [LEN_W-1:0] words_sent_q, words_sent_d;
   logic             underrun_q, underrun_d;
   logic             en_quad_q, en_quad_d;
   logic             xfer_done_q, xfer_done_d;
   logic             load;
   logic             quad;
   logic [7:0]       tgt;

   // At start the quad mode is not latched yet, so the live input decides the target.
   assign quad = (state_q == IDLE) ? en_quad : en_quad_q;
   assign tgt  = quad ? 8'd7 : 8'd31;

   always_comb begin
      state_d        = state_q;
      remaining_d    = remaining_q;
      words_sent_d   = words_sent_q;
      underrun_d     = underrun_q;
      en_quad_d      = en_quad_q;
      xfer_done_d    = 1'b0;
      load           = 1'b0;
      fifo_ready     = 1'b0;
      tx_data        = 32'h0;
      tx_counter     = 8'd0;

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               underrun_d   = 1'b0;
               words_sent_d = '0;
               if (len_words == '0) begin
                  xfer_done_d = 1'b1;
               end else begin
                  en_quad_d   = en_quad;
                  remaining_d = len_words;
                  load        = 1'b1;
                  state_d     = SHIFT;
               end
            end
         end
         SHIFT: begin
            if (abort) begin
               state_d = IDLE;
            end else if (tx_done) begin
               if (remaining_q != '0) begin
                  load = 1'b1;
               end else begin
                  state_d     = IDLE;
                  xfer_done_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A load always consumes one word slot, real or zero-filled.
      if (load) begin
         tx_counter   = tgt;
         remaining_d  = remaining_d - LEN_W'(1);
         words_sent_d = words_sent_d + LEN_W'(1);
         if (fifo_valid) begin
            fifo_ready = 1'b1;
            tx_data    = fifo_data;
         end else begin
            underrun_d = 1'b1;
         end
      end
   end

   assign tx_data_valid  = load;
   assign tx_counter_upd = load;

   always_ff @(posedge sclk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         state_q      <= IDLE;
         remaining_q  <= '0;
         words_sent_q <= '0;
         underrun_q   <= 1'b0;
         en_quad_q    <= 1'b0;
         xfer_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         words_sent_q <= words_sent_d;
         underrun_q   <= underrun_d;
         en_quad_q    <= en_quad_d;
         xfer_done_q  <= xfer_done_d;
      end
   end

   assign busy       = (state_q == SHIFT);
   assign xfer_done  = xfer_done_q;
   assign underrun   = underrun_q;
   assign tx_en_quad = en_quad_q;
   assign words_sent = words_sent_q;

endmodule

// File: tb/tb_spi_slave_tx_feeder.sv
// Table-driven bench for spi_slave_tx_feeder: per-cycle stimulus rows with hand-computed
// strobes and status, plus a hand-written reset-in-flight sequence.
module tb_spi_slave_tx_feeder;

   localparam int LEN_W = 16;

   logic             sclk;
   logic             sys_rstn;
   logic             start;
   logic [LEN_W-1:0] len_words;
   logic             en_quad;
   logic             abort;
   logic [31:0]      fifo_data;
   logic             fifo_valid;
   logic             fifo_ready;
   logic [31:0]      tx_data;
   logic             tx_data_valid;
   logic [7:0]       tx_counter;
   logic             tx_counter_upd;
   logic             tx_en_quad;
   logic             tx_done;
   logic             busy;
   logic             xfer_done;
   logic             underrun;
   logic [LEN_W-1:0] words_sent;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic             st;
      logic [LEN_W-1:0] len;
      logic             q;
      logic             ab;
      logic             fv;
      logic [31:0]      fd;
      logic             dn;
      logic             e_fr;
      logic             e_dv;
      logic             e_upd;
      logic [7:0]       e_cnt;
      logic [31:0]      e_dat;
      logic             e_busy;
      logic             e_xd;
      logic             e_ur;
      logic [LEN_W-1:0] e_ws;
      logic             e_eq;
   } vec_t;

   vec_t vecs[$];

   spi_slave_tx_feeder #(.LEN_W(LEN_W)) dut (
      .sclk           (sclk),
      .sys_rstn       (sys_rstn),
      .start          (start),
      .len_words      (len_words),
      .en_quad        (en_quad),
      .abort          (abort),
      .fifo_data      (fifo_data),
      .fifo_valid     (fifo_valid),
      .fifo_ready     (fifo_ready),
      .tx_data        (tx_data),
      .tx_data_valid  (tx_data_valid),
      .tx_counter     (tx_counter),
      .tx_counter_upd (tx_counter_upd),
      .tx_en_quad     (tx_en_quad),
      .tx_done        (tx_done),
      .busy           (busy),
      .xfer_done      (xfer_done),
      .underrun       (underrun),
      .words_sent     (words_sent)
   );

   // clock / reset
   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic add(input logic st, input int len, input logic q, input logic ab,
                      input logic fv, input logic [31:0] fd, input logic dn,
                      input logic e_fr, input logic e_dv, input logic e_upd,
                      input logic [7:0] e_cnt, input logic [31:0] e_dat,
                      input logic e_busy, input logic e_xd, input logic e_ur,
                      input int e_ws, input logic e_eq);
      vec_t v;
      v.st = st; v.len = LEN_W'(len); v.q = q; v.ab = ab; v.fv = fv; v.fd = fd; v.dn = dn;
      v.e_fr = e_fr; v.e_dv = e_dv; v.e_upd = e_upd; v.e_cnt = e_cnt; v.e_dat = e_dat;
      v.e_busy = e_busy; v.e_xd = e_xd; v.e_ur = e_ur; v.e_ws = LEN_W'(e_ws); v.e_eq = e_eq;
      vecs.push_back(v);
   endtask

   // driver: called just after a rising edge
   task automatic drive(input logic st, input logic [LEN_W-1:0] len, input logic q,
                        input logic ab, input logic fv, input logic [31:0] fd, input logic dn);
      start = st; len_words = len; en_quad = q; abort = ab;
      fifo_valid = fv; fifo_data = fd; tx_done = dn;
   endtask

   task automatic next_cycle();
      @(posedge sclk);
      #1;
   endtask

   initial begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      sys_rstn = 1'b0;
      repeat (2) @(posedge sclk);
      #1;
      sys_rstn = 1'b1;

      // reset state
      @(negedge sclk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_xfer_done", 32'(xfer_done), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      chk("rst_en_quad", 32'(tx_en_quad), 32'd0);
      chk("rst_words_sent", 32'(words_sent), 32'd0);
      chk("rst_fifo_ready", 32'(fifo_ready), 32'd0);
      chk("rst_upd", 32'(tx_counter_upd), 32'd0);
      next_cycle();

      //   st len q ab fv fd            dn | fr dv upd cnt dat         busy xd ur ws eq
      // single mode, len=2, back-to-back reload
      add(0, 0, 0, 0, 0, 32'h0,          0,  0, 0, 0, 0,  32'h0,          0, 0, 0, 0, 0);
      add(1, 2, 0, 0, 1, 32'hA5A5_0001,  0,  1, 1, 1, 31, 32'hA5A5_0001,  0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 32'h5A5A_0002,  0,  0, 0, 0, 0,  32'h0,          1, 0, 0, 1, 0);
      add(0, 0, 0, 0, 1, 32'h5A5A_0002,  1,  1, 1, 1, 31, 32'h5A5A_0002,  1, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 32'h0,          0,  0, 0, 0, 0,  32'h0,          1, 0, 0, 2, 0);
      add(0, 0, 0, 0, 0, 32'h0,          1,  0, 0, 0, 0,  32'h0,          1, 0, 0, 2, 0);
      add(0, 0, 0, 0, 0, 32'h0,          0,  0, 0, 0, 0,  32'h0,          0, 1, 0, 2, 0);
      add(0, 0, 0, 0, 0, 32'h0,          0,  0, 0, 0, 0,  32'h0,          0, 0, 0, 2, 0);
      // quad mode, len=3, en_quad dropped mid-transfer
      add(1, 3, 1, 0, 1, 32'h0000_0011,  0,  1, 1, 1, 7,  32'h0000_0011,  0, 0, 0, 2, 0);
      add(0, 0, 0, 0, 1, 32'h0000_0022,  1,  1, 1, 1, 7,  32'h0000_0022,  1, 0, 0, 1, 1);
      add(0, 0, 0, 0, 1, 32'h0000_0033,  1,  1, 1, 1, 7,  32'h0000_0033,  1, 0, 0, 2, 1);
      add(0, 0, 0, 0, 1, 32'h0000_0044,  1,  0, 0, 0, 0,  32'h0,          1, 0, 0, 3, 1);
      add(0, 0, 0, 0, 1, 32'h0000_0044,  0,  0, 0, 0, 0,  32'h0,          0, 1, 0, 3, 1);
      // underrun: second word missing
      add(1, 2, 0, 0, 1, 32'h0000_0077,  0,  1, 1, 1, 31, 32'h0000_0077,  0, 0, 0, 3, 1);
      add(0, 0, 0, 0, 0, 32'hDEAD_BEEF,  1,  0, 1, 1, 31, 32'h0,          1, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 32'h0,          0,  0, 0, 0, 0,  32'h0,          1, 0, 1, 2, 0);
      add(0, 0, 0, 0, 0, 32'h0,          1,  0, 0, 0, 0,  32'h0,          1, 0, 1, 2, 0);
      add(0, 0, 0, 0, 0, 32'h0,          0,  0, 0, 0, 0,  32'h0,          0, 1, 1, 2, 0);
      // next start clears underrun
      add(1, 1, 0, 0, 1, 32'h0000_0099,  0,  1, 1, 1, 31, 32'h0000_0099,  0, 0, 1, 2, 0);
      add(0, 0, 0, 0, 1, 32'h0000_00AB,  0,  0, 0, 0, 0,  32'h0,          1, 0, 0, 1, 0);
      add(0, 0, 0, 0, 1, 32'h0000_00AB,  1,  0, 0, 0, 0,  32'h0,          1, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 32'h0,          0,  0, 0, 0, 0,  32'h0,          0, 1, 0, 1, 0);
      // abort coincident with tx_done, remaining=1
      add(1, 2, 0, 0, 1, 32'h0000_00AA,  0,  1, 1, 1, 31, 32'h0000_00AA,  0, 0, 0, 1, 0);
      add(0, 0, 0, 1, 1, 32'h0000_00BB,  1,  0, 0, 0, 0,  32'h0,          1, 0, 0, 1, 0);
      add(0, 0, 0, 0, 1, 32'h0000_00BB,  0,  0, 0, 0, 0,  32'h0,          0, 0, 0, 1, 0);
      // len=0 start
      add(1, 0, 0, 0, 1, 32'h0000_00CC,  0,  0, 0, 0, 0,  32'h0,          0, 0, 0, 1, 0);
      add(0, 0, 0, 0, 1, 32'h0000_00CC,  0,  0, 0, 0, 0,  32'h0,          0, 1, 0, 0, 0);
      // start while busy is ignored
      add(1, 1, 0, 0, 1, 32'h0000_0005,  0,  1, 1, 1, 31, 32'h0000_0005,  0, 0, 0, 0, 0);
      add(1, 5, 0, 0, 1, 32'h0000_0006,  0,  0, 0, 0, 0,  32'h0,          1, 0, 0, 1, 0);
      add(0, 0, 0, 0, 1, 32'h0000_0006,  1,  0, 0, 0, 0,  32'h0,          1, 0, 0, 1, 0);
      add(0, 0, 0, 0, 1, 32'h0000_0006,  0,  0, 0, 0, 0,  32'h0,          0, 1, 0, 1, 0);
      // abort beats start in IDLE
      add(1, 1, 0, 1, 1, 32'h0000_0007,  0,  0, 0, 0, 0,  32'h0,          0, 0, 0, 1, 0);
      add(0, 0, 0, 0, 1, 32'h0000_0007,  0,  0, 0, 0, 0,  32'h0,          0, 0, 0, 1, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].st, vecs[i].len, vecs[i].q, vecs[i].ab, vecs[i].fv, vecs[i].fd, vecs[i].dn);
         @(negedge sclk);
         chk($sformatf("v%0d_fifo_ready", i), 32'(fifo_ready), 32'(vecs[i].e_fr));
         chk($sformatf("v%0d_tx_data_valid", i), 32'(tx_data_valid), 32'(vecs[i].e_dv));
         chk($sformatf("v%0d_tx_counter_upd", i), 32'(tx_counter_upd), 32'(vecs[i].e_upd));
         chk($sformatf("v%0d_tx_counter", i), 32'(tx_counter), 32'(vecs[i].e_cnt));
         chk($sformatf("v%0d_tx_data", i), tx_data, vecs[i].e_dat);
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
         chk($sformatf("v%0d_xfer_done", i), 32'(xfer_done), 32'(vecs[i].e_xd));
         chk($sformatf("v%0d_underrun", i), 32'(underrun), 32'(vecs[i].e_ur));
         chk($sformatf("v%0d_words_sent", i), 32'(words_sent), 32'(vecs[i].e_ws));
         chk($sformatf("v%0d_tx_en_quad", i), 32'(tx_en_quad), 32'(vecs[i].e_eq));
         next_cycle();
      end

      // reset in the middle of a quad transfer
      drive(1'b1, LEN_W'(3), 1'b1, 1'b0, 1'b1, 32'h0000_1234, 1'b0);
      next_cycle();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h0000_5678, 1'b0);
      @(negedge sclk);
      chk("mid_busy_before_rst", 32'(busy), 32'd1);
      chk("mid_ws_before_rst", 32'(words_sent), 32'd1);
      next_cycle();
      sys_rstn = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ws", 32'(words_sent), 32'd0);
      chk("mid_rst_en_quad", 32'(tx_en_quad), 32'd0);
      next_cycle();
      sys_rstn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h0000_9000 + 32'(k), 1'b1);
         @(negedge sclk);
         chk($sformatf("post_rst%0d_fifo_ready", k), 32'(fifo_ready), 32'd0);
         chk($sformatf("post_rst%0d_dv", k), 32'(tx_data_valid), 32'd0);
         chk($sformatf("post_rst%0d_busy", k), 32'(busy), 32'd0);
         chk($sformatf("post_rst%0d_xfer_done", k), 32'(xfer_done), 32'd0);
         next_cycle();
      end

      // underrun on the very first word at start
      drive(1'b1, LEN_W'(1), 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
      @(negedge sclk);
      chk("ur_start_fifo_ready", 32'(fifo_ready), 32'd0);
      chk("ur_start_tx_data", tx_data, 32'h0);
      chk("ur_start_upd", 32'(tx_counter_upd), 32'd1);
      next_cycle();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge sclk);
      chk("ur_start_flag", 32'(underrun), 32'd1);
      chk("ur_start_ws", 32'(words_sent), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
